// File: rtl/mlp_pkg.sv
// mlp_pkg: shared FSM state type and width helpers
// for the PE and its feeder.
package mlp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_WAIT,
    S_RESULT,
    S_FIN
  } state_e;

  localparam int PE_LAT_DEF = 2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int waddr_w(
    input int neurons,
    input int inputs
  );
    return idx_w(neurons * inputs);
  endfunction

endpackage

// File: rtl/pe_feeder_if.sv
// pe_feeder_if: PE beat ports plus the
// downstream result handshake.
interface pe_feeder_if
  import mlp_pkg::*;
#(
  parameter int IW = 8,
  parameter int WW = 8,
  parameter int OW = 8,
  parameter int NW = idx_w(4)
);
  logic          pe_new_weight;
  logic [WW-1:0] pe_weight;
  logic          pe_input_available;
  logic [IW-1:0] pe_input_data;
  logic [OW-1:0] pe_out;
  logic          res_valid;
  logic [OW-1:0] res_data;
  logic [NW-1:0] res_neuron;
  logic          res_ready;

  modport master (
    output pe_new_weight,
    output pe_weight,
    output pe_input_available,
    output pe_input_data,
    output res_valid,
    output res_data,
    output res_neuron,
    input  pe_out,
    input  res_ready
  );

  modport slave (
    input  pe_new_weight,
    input  pe_weight,
    input  pe_input_available,
    input  pe_input_data,
    input  res_valid,
    input  res_data,
    input  res_neuron,
    output pe_out,
    output res_ready
  );
endinterface

// File: rtl/feeder_counter.sv
// feeder_counter: mod-N counter with enable,
// wrap pulse and synchronous clear.
module feeder_counter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign cnt_o  = cnt_q;
  assign wrap_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/pe_feeder.sv
// pe_feeder: streams one input vector and a sequence
// of weight sets into a single PE, one neuron at a time.
module pe_feeder
  import mlp_pkg::*;
#(
  parameter  int INPUT_WIDTH  = 8,
  parameter  int WEIGHT_WIDTH = 8,
  parameter  int INPUT_NUM    = 4,
  parameter  int NEURON_NUM   = 4,
  parameter  int PE_OUT_WIDTH = 8,
  parameter  int PE_LAT       = PE_LAT_DEF,
  localparam int IA_W = idx_w(INPUT_NUM),
  localparam int N_W  = idx_w(NEURON_NUM),
  localparam int WA_W = waddr_w(NEURON_NUM, INPUT_NUM),
  localparam int T_W  = idx_w(PE_LAT + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic                    in_wr_en,
  input  logic [IA_W-1:0]         in_wr_addr,
  input  logic [INPUT_WIDTH-1:0]  in_wr_data,
  output logic [WA_W-1:0]         w_rd_addr,
  input  logic [WEIGHT_WIDTH-1:0] w_rd_data,
  pe_feeder_if.master             bus
);
  localparam logic [N_W-1:0] NRN_LAST =
    N_W'(NEURON_NUM - 1);

  state_e state_q, state_d;

  logic [IA_W-1:0] beat;
  logic [N_W-1:0]  nrn;
  logic [T_W-1:0]  tmr_unused;
  logic beat_wrap, nrn_wrap, tmr_wrap;
  logic idle, beat_en, wait_en;
  logic issue_w, issue_i, accept, has_next;
  logic [WA_W-1:0] next_base;

  logic [INPUT_WIDTH-1:0]  buf_q [INPUT_NUM];
  logic                    nw_q, ia_q, rv_q;
  logic [INPUT_WIDTH-1:0]  id_q;
  logic [PE_OUT_WIDTH-1:0] rd_q;
  logic [N_W-1:0]          rn_q;

  assign idle     = (state_q == S_IDLE);
  assign beat_en  = (state_q == S_LOAD) ||
                    (state_q == S_STREAM);
  assign wait_en  = (state_q == S_WAIT);
  assign accept   = (state_q == S_RESULT) &&
                    rv_q && bus.res_ready;
  assign has_next = (nrn != NRN_LAST);

  feeder_counter #(.N(INPUT_NUM), .W(IA_W)) u_beat (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (idle),
    .en_i   (beat_en),
    .cnt_o  (beat),
    .wrap_o (beat_wrap)
  );

  feeder_counter #(.N(NEURON_NUM), .W(N_W)) u_nrn (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (idle),
    .en_i   (accept),
    .cnt_o  (nrn),
    .wrap_o (nrn_wrap)
  );

  feeder_counter #(.N(PE_LAT + 1), .W(T_W)) u_tmr (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (idle),
    .en_i   (wait_en),
    .cnt_o  (tmr_unused),
    .wrap_o (tmr_wrap)
  );

  always_comb begin
    state_d = state_q;
    issue_w = 1'b0;
    issue_i = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        issue_w = 1'b1;
        if (beat_wrap) state_d = S_STREAM;
      end
      S_STREAM: begin
        issue_i = 1'b1;
        issue_w = has_next;
        if (beat_wrap) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tmr_wrap) state_d = S_RESULT;
      end
      S_RESULT: begin
        if (accept)
          state_d = nrn_wrap ? S_FIN : S_STREAM;
      end
      S_FIN: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Prefetch address for the next neuron's set.
  assign next_base =
    WA_W'((int'(nrn) + 1) * INPUT_NUM);

  always_comb begin
    w_rd_addr = '0;
    if (issue_w) begin
      if (state_q == S_LOAD)
        w_rd_addr = WA_W'(beat);
      else
        w_rd_addr = next_base + WA_W'(beat);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      nw_q    <= 1'b0;
      ia_q    <= 1'b0;
      id_q    <= '0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
      rn_q    <= '0;
      for (int i = 0; i < INPUT_NUM; i++)
        buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      nw_q    <= issue_w;
      ia_q    <= issue_i;
      id_q    <= issue_i ? buf_q[beat] : '0;
      if (in_wr_en && idle)
        buf_q[in_wr_addr] <= in_wr_data;
      if (wait_en && tmr_wrap) begin
        rv_q <= 1'b1;
        rd_q <= bus.pe_out;
        rn_q <= nrn;
      end else if (accept) begin
        rv_q <= 1'b0;
      end
    end
  end

  // Weight is the ROM output itself; the registered
  // strobe lines it up with the 1-cycle ROM read.
  assign bus.pe_new_weight      = nw_q;
  assign bus.pe_weight          = nw_q ? w_rd_data : '0;
  assign bus.pe_input_available = ia_q;
  assign bus.pe_input_data      = id_q;
  assign bus.res_valid          = rv_q;
  assign bus.res_data           = rd_q;
  assign bus.res_neuron         = rn_q;
endmodule

// File: tb/tb_pe_feeder.sv
// tb_pe_feeder: directed bench for pe_feeder with a
// dot-product PE model and a weight ROM holding its address.
module tb_pe_feeder;
  import mlp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       in_wr_en = 1'b0;
  logic [1:0] in_wr_addr = '0;
  logic [7:0] in_wr_data = '0;
  logic       res_ready = 1'b1;

  logic [2:0] wa_a;
  logic [7:0] wd_a;
  logic [1:0] wa_b;
  logic [7:0] wd_b;
  logic busy_a, done_a, busy_b, done_b;

  pe_feeder_if #(.IW(8), .WW(8), .OW(8), .NW(1)) ifa();
  pe_feeder_if #(.IW(8), .WW(8), .OW(8), .NW(1)) ifb();

  pe_feeder #(
    .INPUT_NUM(4), .NEURON_NUM(2), .PE_LAT(2)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy_a), .done(done_a),
    .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr),
    .in_wr_data(in_wr_data),
    .w_rd_addr(wa_a), .w_rd_data(wd_a),
    .bus(ifa)
  );

  pe_feeder #(
    .INPUT_NUM(4), .NEURON_NUM(1), .PE_LAT(2)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy_b), .done(done_b),
    .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr),
    .in_wr_data(in_wr_data),
    .w_rd_addr(wa_b), .w_rd_data(wd_b),
    .bus(ifb)
  );

  always @(posedge clk) begin
    wd_a <= {5'd0, wa_a};
    wd_b <= {6'd0, wa_b};
  end

  assign ifa.res_ready = res_ready;
  assign ifb.res_ready = 1'b1;
  assign ifb.pe_out    = 8'h5A;

  // PE model: weights queue up, each input beat consumes one;
  // the sum is visible on pe_out for exactly one cycle, PE_LAT
  // cycles after the last input beat.
  logic [7:0]  wq[$];
  logic [15:0] acc = '0;
  int          n_in = 0;
  logic [7:0]  p1 = '0, p2 = '0;
  logic        p1v = 1'b0, p2v = 1'b0;
  logic [7:0]  wcur;

  always @(posedge clk) begin
    if (reset) begin
      wq.delete();
      acc  = '0;
      n_in = 0;
      p1v <= 1'b0;
      p2v <= 1'b0;
    end else begin
      if (ifa.pe_new_weight) wq.push_back(ifa.pe_weight);
      p2  <= p1;
      p2v <= p1v;
      p1v <= 1'b0;
      if (ifa.pe_input_available) begin
        wcur = (wq.size() > 0) ? wq.pop_front() : 8'h00;
        acc  = acc + wcur * ifa.pe_input_data;
        n_in = n_in + 1;
        if (n_in == 4) begin
          p1  <= acc[7:0];
          p1v <= 1'b1;
          acc  = '0;
          n_in = 0;
        end
      end
    end
  end

  assign ifa.pe_out = p2v ? p2 : 8'hAA;

  int n_chk = 0;
  int n_err = 0;
  int bufv[4];

  int t_nw[64], t_w[64], t_ia[64], t_id[64], t_wa[64];
  int t_rv[64], t_rd[64], t_rn[64], t_dn[64], t_bz[64];
  int t_bnw[64], t_bia[64], t_brv[64], t_brd[64];
  int t_bdn[64];

  task automatic chk(input string tag, input int obs,
                     input int want);
    n_chk++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d",
               tag, obs, want);
    end
  endtask

  task automatic wr_buf(input int v0, input int v1,
                        input int v2, input int v3);
    int v[4];
    v = '{v0, v1, v2, v3};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_wr_en   = 1'b1;
      in_wr_addr = 2'(k);
      in_wr_data = 8'(v[k]);
      bufv[k]    = v[k];
    end
    @(negedge clk);
    in_wr_en = 1'b0;
  endtask

  // Sample every cycle on the falling edge, then drive this
  // cycle's inputs; cycle 0 is the one where start is sampled.
  task automatic run(input int ncyc, input int stall,
                     input int rst_at, input bit poke);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      t_nw[c]  = int'(ifa.pe_new_weight);
      t_w[c]   = int'(ifa.pe_weight);
      t_ia[c]  = int'(ifa.pe_input_available);
      t_id[c]  = int'(ifa.pe_input_data);
      t_wa[c]  = int'(wa_a);
      t_rv[c]  = int'(ifa.res_valid);
      t_rd[c]  = int'(ifa.res_data);
      t_rn[c]  = int'(ifa.res_neuron);
      t_dn[c]  = int'(done_a);
      t_bz[c]  = int'(busy_a);
      t_bnw[c] = int'(ifb.pe_new_weight);
      t_bia[c] = int'(ifb.pe_input_available);
      t_brv[c] = int'(ifb.res_valid);
      t_brd[c] = int'(ifb.res_data);
      t_bdn[c] = int'(done_b);
      start = (c == 0) ||
              (poke && (c == 5 || c == 12 + stall + 9));
      reset      = (c == rst_at);
      in_wr_en   = poke && (c == 6);
      in_wr_addr = 2'd0;
      in_wr_data = 8'hFF;
      res_ready  = !(c >= 12 && c < 12 + stall);
    end
    @(negedge clk);
    start     = 1'b0;
    reset     = 1'b0;
    in_wr_en  = 1'b0;
    res_ready = 1'b1;
  endtask

  // a = cycle the first result is accepted; rst = reset cycle.
  task automatic check_trace(input int a, input int rst,
                             input int ncyc);
    int r0, r1;
    int e_nw, e_w, e_ia, e_id, e_wa;
    int e_rv, e_rd, e_rn, e_dn, e_bz;
    r0 = 0;
    r1 = 0;
    for (int k = 0; k < 4; k++) begin
      r0 += k * bufv[k];
      r1 += (4 + k) * bufv[k];
    end
    r0 &= 255;
    r1 &= 255;
    for (int c = 0; c < ncyc; c++) begin
      e_nw = int'(c >= 2 && c <= 9);
      e_w  = e_nw ? c - 2 : 0;
      e_ia = int'((c >= 6 && c <= 9) ||
                  (c >= a + 2 && c <= a + 5));
      e_id = e_ia ? bufv[(c <= 9) ? c - 6 : c - a - 2] : 0;
      e_wa = (c >= 1 && c <= 8) ? c - 1 : 0;
      e_rv = int'((c >= 12 && c <= a) || c == a + 8);
      e_rd = (c <= a) ? r0 : r1;
      e_rn = (c <= a) ? 0 : 1;
      e_dn = int'(c == a + 9);
      e_bz = int'(c >= 1 && c <= a + 8);
      if (rst >= 0 && c > rst) begin
        e_nw = 0; e_ia = 0; e_id = 0; e_wa = 0;
        e_rv = 0; e_dn = 0; e_bz = 0;
      end
      chk($sformatf("new_weight c%0d", c), t_nw[c], e_nw);
      if (e_nw != 0)
        chk($sformatf("weight c%0d", c), t_w[c], e_w);
      chk($sformatf("input_avail c%0d", c), t_ia[c], e_ia);
      chk($sformatf("input_data c%0d", c), t_id[c], e_id);
      chk($sformatf("w_rd_addr c%0d", c), t_wa[c], e_wa);
      chk($sformatf("res_valid c%0d", c), t_rv[c], e_rv);
      if (e_rv != 0) begin
        chk($sformatf("res_data c%0d", c), t_rd[c], e_rd);
        chk($sformatf("res_neuron c%0d", c), t_rn[c], e_rn);
      end
      chk($sformatf("done c%0d", c), t_dn[c], e_dn);
      chk($sformatf("busy c%0d", c), t_bz[c], e_bz);
    end
  endtask

  task automatic check_single(input int ncyc);
    int nw, ia, rv, dn;
    nw = 0; ia = 0; rv = 0; dn = 0;
    for (int c = 0; c < ncyc; c++) begin
      nw += t_bnw[c];
      ia += t_bia[c];
      rv += t_brv[c];
      dn += t_bdn[c];
      if (t_brv[c] != 0)
        chk($sformatf("N1 res_data c%0d", c), t_brd[c], 8'h5A);
    end
    chk("N1 weight beats", nw, 4);
    chk("N1 input beats", ia, 4);
    chk("N1 result cycles", rv, 1);
    chk("N1 done pulses", dn, 1);
    chk("N1 no weight c6", t_bnw[6], 0);
    chk("N1 result at c12", t_brv[12], 1);
    chk("N1 done at c13", t_bdn[13], 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst busy", int'(busy_a), 0);
    chk("rst done", int'(done_a), 0);
    chk("rst res_valid", int'(ifa.res_valid), 0);
    chk("rst new_weight", int'(ifa.pe_new_weight), 0);
    chk("rst input_avail", int'(ifa.pe_input_available), 0);
    chk("rst input_data", int'(ifa.pe_input_data), 0);
    chk("rst w_rd_addr", int'(wa_a), 0);
    reset = 1'b0;

    wr_buf(1, 2, 3, 4);
    run(24, 0, -1, 1'b0);
    check_trace(12, -1, 24);
    chk("run1 res0", t_rd[12], 20);
    chk("run1 res1", t_rd[20], 60);
    check_single(24);

    run(34, 10, -1, 1'b0);
    check_trace(22, -1, 34);

    run(20, 0, 7, 1'b0);
    check_trace(12, 7, 20);
    for (int k = 0; k < 4; k++) bufv[k] = 0;
    run(24, 0, -1, 1'b0);
    check_trace(12, -1, 24);

    wr_buf(2, 0, 5, 1);
    run(24, 0, -1, 1'b1);
    check_trace(12, -1, 24);
    chk("run5 res0", t_rd[12], 13);
    chk("run5 res1", t_rd[20], 45);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pe_feeder.md
Name: pe_feeder

Overview:
- Initiator side of the PE weight/input protocol.
- Streams one input vector and NEURON_NUM weight sets into a single PE, sequencing one neuron at a time.
- Overlaps the weight load for neuron n+1 with the input stream for neuron n, using the PE's double-buffered weight SRAMs.
- Samples pe_out after each neuron and hands the result downstream with a valid/ready handshake.

Parameters:
- INPUT_WIDTH, 8, width of one input sample.
- WEIGHT_WIDTH, 8, width of one weight.
- INPUT_NUM, 4, inputs per neuron, which is also weights per set.
- NEURON_NUM, 4, number of neurons (weight sets) processed per start.
- PE_OUT_WIDTH, 8, PE result width.
- PE_LAT, 2, cycles from the last input beat until pe_out is valid.

Ports:
- clk in 1: clock.
- reset in 1: synchronous, active-high.
- start in 1: begin a run; sampled only in IDLE.
- busy out 1: high from the cycle after start is accepted until done.
- done out 1: one-cycle pulse when the run completes.
- in_wr_en in 1: write one entry of the input buffer.
- in_wr_addr in clog2(INPUT_NUM): input buffer write index.
- in_wr_data in INPUT_WIDTH: input buffer write data.
- w_rd_addr out clog2(NEURON_NUM*INPUT_NUM): weight ROM address; the ROM has 1-cycle read latency.
- w_rd_data in WEIGHT_WIDTH: weight ROM data.
- pe_new_weight out 1: weight beat valid.
- pe_weight out WEIGHT_WIDTH: weight beat data.
- pe_input_available out 1: input beat valid.
- pe_input_data out INPUT_WIDTH: input beat data.
- pe_out in PE_OUT_WIDTH: PE result.
- res_valid out 1: result valid.
- res_data out PE_OUT_WIDTH: captured result.
- res_neuron out clog2(NEURON_NUM): neuron index of the result.
- res_ready in 1: downstream accept.

Behaviour:
- Reset: state IDLE; all outputs 0; input buffer cleared to 0; counters 0. Reset mid-run aborts with no done pulse.
- Input buffer: INPUT_NUM x INPUT_WIDTH registers. Written when in_wr_en=1 and state is IDLE; writes in any other state are ignored.
- FSM states: IDLE -> LOAD -> STREAM -> WAIT -> RESULT -> (STREAM or FIN) -> IDLE.
- IDLE: start=1 moves to LOAD. start while busy is ignored.
- LOAD:
  - For INPUT_NUM cycles, issue w_rd_addr = k for k = 0..INPUT_NUM-1 (weight set 0).
  - Then go to STREAM with n=0.
- STREAM (neuron n):
  - For INPUT_NUM cycles, issue input index k.
  - If n+1 < NEURON_NUM, concurrently issue w_rd_addr = (n+1)*INPUT_NUM + k.
  - Then go to WAIT.
- Beat alignment:
  - Every issued beat appears on the PE ports exactly one cycle after issue.
  - pe_new_weight and pe_input_available are registered issue flags.
  - pe_weight = w_rd_data, passed through without a register.
  - pe_input_data is registered from the buffer, so weight and input beats stay aligned.
  - Both valid strobes are contiguous for INPUT_NUM cycles per set, with no gaps.
  - Outside a beat: strobes are 0 and pe_input_data is 0.
- WAIT:
  - Count PE_LAT cycles, measured from the cycle of the last visible input beat.
  - On expiry: res_data <= pe_out, res_neuron <= n, res_valid <= 1; go to RESULT.
- RESULT:
  - Hold res_* stable until res_valid & res_ready.
  - On accept: res_valid <= 0.
  - If n = NEURON_NUM-1, go to FIN; otherwise n++ and go to STREAM.
  - res_ready is ignored while res_valid=0.
- FIN: done=1 for one cycle, busy=0 in the same cycle, next state IDLE.
- Latency:
  - start sampled at cycle 0.
  - First weight beat visible at cycle 2.
  - First input beat visible at cycle INPUT_NUM+2.
  - First res_valid at cycle 2*INPUT_NUM+1+PE_LAT+1.
- Boundary cases:
  - NEURON_NUM=1: no overlapping weight beats during STREAM.
  - Counters wrap to 0 at the end of each set; w_rd_addr never exceeds NEURON_NUM*INPUT_NUM-1.
  - start in the FIN cycle is ignored.

Decomposition:
- Shared package mlp_pkg holds:
  - the state enum typedef;
  - address-width localparam functions (clog2-based) reused by PE and feeder;
  - the PE_LAT default constant.
- One sub-module, feeder_counter: a parameterised mod-N counter with enable, wrap pulse and synchronous clear. It is instantiated for the beat index, the neuron index and the wait timer.

Test Plan:
1. INPUT_NUM=4, NEURON_NUM=2, buffer={1,2,3,4}, ROM=0..7, res_ready=1:
   - pe_new_weight high at cycles 2-5 with weights 0,1,2,3;
   - cycles 6-9 carry inputs 1,2,3,4 concurrently with weights 4,5,6,7;
   - results for neuron 0 then neuron 1; done pulses once.
2. Bench PE model returns the dot product. Expected results: 0*1+1*2+2*3+3*4 = 20, then 4*1+5*2+6*3+7*4 = 60. res_neuron = 0 then 1.
3. Backpressure: hold res_ready=0 for 10 cycles after the first res_valid:
   - res_data stays 20;
   - no input or weight beats during the stall;
   - the second stream starts the cycle after acceptance.
4. Reset asserted on the second input beat: all outputs 0 next cycle, no done; a fresh start replays from weight 0.
5. start pulsed while busy, and in_wr_en while busy: no effect; buffer unchanged, verified by the next run's input beats.
6. NEURON_NUM=1: exactly 4 weight beats and 4 input beats, one result, done once.
